spi_slave_shifter: RTL



---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_edge_detect.sv | 37 +++
 rtl/spi_slave_shifter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared defaults and state encoding for the SPI slave shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DEF_WORD_WIDTH = 8;
    localparam logic [DEF_WORD_WIDTH-1:0] DEF_IDLE_WORD = {DEF_WORD_WIDTH{1'b1}};

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_detect
//  Description : Registers previous sck/cs levels and flags their edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_in,
    input  logic cs_in,
    output logic rise,
    output logic fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic r_sck_prev;
    logic r_cs_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_prev <= 1'b0;
            r_cs_prev  <= 1'b1;
        end else begin
            r_sck_prev <= sck_in;
            r_cs_prev  <= cs_in;
        end
    end

    assign rise    =  sck_in & ~r_sck_prev;
    assign fall    = ~sck_in &  r_sck_prev;
    assign cs_fall = ~cs_in  &  r_cs_prev;
    assign cs_rise =  cs_in  & ~r_cs_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_shifter
//  Description : Mode-0 SPI slave datapath: MOSI deserializer, MISO serializer
//                with a single-entry transmit holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int                    WORD_WIDTH = DEF_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD  = {WORD_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_in,
    output logic                  sdo,
    output logic                  sdo_oe,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  frame_start,
    output logic                  frame_end
);

    localparam int              CW       = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WORD_WIDTH - 1);

    logic w_rise, w_fall, w_cs_fall, w_cs_rise;

    spi_edge_detect u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck_in  (sck_in),
        .cs_in   (cs_in),
        .rise    (w_rise),
        .fall    (w_fall),
        .cs_fall (w_cs_fall),
        .cs_rise (w_cs_rise)
    );

    state_t                r_state;
    logic [CW-1:0]         r_bit_count;
    logic [WORD_WIDTH-2:0] r_rx_shift;
    logic [WORD_WIDTH-1:0] r_tx_shift;
    logic [WORD_WIDTH-1:0] r_hold_data;
    logic                  r_cs_armed;

    logic                  w_start;
    logic                  w_tx_edge;
    logic                  w_load;
    logic                  w_capture;
    logic [WORD_WIDTH-1:0] w_rx_next;

    // A frame may only start after cs has been seen high since reset, so a
    // reset taken mid-frame cannot turn the still-low cs into a new frame.
    assign w_start   = (r_state == S_IDLE) & w_cs_fall & r_cs_armed;
    assign w_tx_edge = (r_state == S_ACTIVE) & ~w_cs_rise & w_fall;
    assign w_load    = w_start | (w_tx_edge & (r_bit_count == '0));
    assign w_capture = tx_valid & tx_ready;
    assign w_rx_next = {r_rx_shift, sdi_in};

    assign sdo = r_tx_shift[WORD_WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_count <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= IDLE_WORD;
            r_hold_data <= '0;
            r_cs_armed  <= 1'b0;
            sdo_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;

            if (cs_in) begin
                r_cs_armed <= 1'b1;
            end

            if (w_capture) begin
                r_hold_data <= tx_data;
                tx_ready    <= 1'b0;
            end

            // A load sees the pre-capture holding state; a same-cycle capture
            // is kept for the following boundary.
            if (w_load) begin
                if (!tx_ready) begin
                    r_tx_shift <= r_hold_data;
                    tx_ready   <= 1'b1;
                end else begin
                    r_tx_shift  <= IDLE_WORD;
                    tx_underrun <= 1'b1;
                end
            end else if (w_tx_edge) begin
                r_tx_shift <= {r_tx_shift[WORD_WIDTH-2:0], 1'b1};
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_ACTIVE;
                        sdo_oe      <= 1'b1;
                        frame_start <= 1'b1;
                        r_bit_count <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state     <= S_IDLE;
                        sdo_oe      <= 1'b0;
                        frame_end   <= 1'b1;
                        r_bit_count <= '0;
                    end else if (w_rise) begin
                        r_rx_shift <= w_rx_next[WORD_WIDTH-2:0];
                        if (r_bit_count == LAST_BIT) begin
                            rx_data     <= w_rx_next;
                            rx_valid    <= 1'b1;
                            r_bit_count <= '0;
                        end else begin
                            r_bit_count <= r_bit_count + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
